fc_layer: RTL

Fully-connected output stage that runs after the 3x3 convolution / 2x2 max-pool stage has filled the layer-1 memory with its 32x32 pooled map. For each of N_OUT output neurons it reads all N_IN pooled features and the matching weights, multiply-accumulates in Q4.16, adds a per-neuron bias, rounds, applies ReLU/saturation, and writes one 20-bit result to the output-layer memory. It shares the `ready`/`busy` start handshake and the `csel`-selected memory ports used by the upstream stage.

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_mac.sv | 75 +++++++
 rtl/fc_layer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared widths, csel codes and FSM state type for the fully-connected stage
//
// Holds the Q4.16 data width, fraction bits and accumulator width, the
// memory-select codes driven on csel, and the FSM state type used by fc_layer.
package fc_pkg;

    localparam int DATA_W = 20;
    localparam int FRAC_W = 16;
    localparam int ACC_W  = 51;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L1   = 3'b011;
    localparam logic [2:0] CSEL_OUT  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } fc_state_e;

endpackage

// File: rtl/fc_mac.sv
// rtl/fc_mac.sv - multiply-accumulate, bias add and round/ReLU/saturate datapath
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   acc_clr          clear the accumulator (has priority)
//   mac_en           acc += feat * wgt (20x20 signed Q4.16 product)
//   bias_en          acc += wgt << 16 (bias aligned to product scale)
//   feat, wgt        signed Q4.16 operands from the memories
//   result           rounded, saturated Q4.16 value of the accumulator
// Macro FC_RELU_EN: when defined, negative rounded results are forced to 0.
module fc_mac
    import fc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_clr,
    input  logic              mac_en,
    input  logic              bias_en,
    input  logic [DATA_W-1:0] feat,
    input  logic [DATA_W-1:0] wgt,
    output logic [DATA_W-1:0] result
);

    // Adding half an LSB then arithmetic-shifting gives acc[50:16] + acc[15].
    localparam logic signed [ACC_W:0] RND_HALF =
        {{(ACC_W - FRAC_W + 1){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_POS =
        {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_NEG =
        {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    rnd;

    assign prod = $signed(feat) * $signed(wgt);

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end else if (bias_en) begin
            acc_d = acc_q + {{(ACC_W - DATA_W - FRAC_W){wgt[DATA_W-1]}}, wgt, {FRAC_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign rnd = ($signed({acc_q[ACC_W-1], acc_q}) + RND_HALF) >>> FRAC_W;

    always_comb begin
        if (rnd > SAT_POS) begin
            result = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (rnd < SAT_NEG) begin
            result = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            result = rnd[DATA_W-1:0];
        end
`ifdef FC_RELU_EN
        if (rnd[ACC_W]) begin
            result = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/fc_layer.sv
// rtl/fc_layer.sv - fully-connected output stage: FSM, counters and memory ports
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-low reset
//   ready / busy             start request (sampled in IDLE) / run in progress
//   crd, caddr_rd, cdata_rd  layer-1 feature read (data one cycle after address)
//   waddr, wdata             weight/bias read (data one cycle after address)
//   cwr, caddr_wr, cdata_wr  output-layer write, one per neuron
//   csel                     memory select: 011 reading, 101 writing, 000 idle
// Macro FC_RELU_EN (see fc_mac): ReLU on the written result.
module fc_layer
    import fc_pkg::*;
#(
    parameter int N_IN    = 1024,
    parameter int N_OUT   = 10,
    parameter int WADDR_W = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    output logic               busy,
    output logic               crd,
    output logic [11:0]        caddr_rd,
    input  logic [DATA_W-1:0]  cdata_rd,
    output logic [WADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    output logic               cwr,
    output logic [11:0]        caddr_wr,
    output logic [DATA_W-1:0]  cdata_wr,
    output logic [2:0]         csel
);

    fc_state_e          state_q, state_d;
    logic [11:0]        i_q, i_d;
    logic [11:0]        n_q, n_d;
    logic [WADDR_W-1:0] wbase_q, wbase_d;   // n*(N_IN+1), stepped per neuron
    logic               busy_q, busy_d;
    logic               acc_clr, mac_en, bias_en;
    logic [DATA_W-1:0]  result;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        n_d     = n_q;
        wbase_d = wbase_q;
        // busy stays up through DONE and the IDLE cycle that follows it.
        busy_d  = (state_q != S_IDLE);
        acc_clr = 1'b0;
        mac_en  = 1'b0;
        bias_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d = S_MAC;
                    i_d     = '0;
                    n_d     = '0;
                    wbase_d = '0;
                    busy_d  = 1'b1;
                    acc_clr = 1'b1;
                end
            end
            S_MAC: begin
                // Data for index i-1 arrives while index i is addressed.
                mac_en = (i_q != 12'd0);
                i_d    = i_q + 12'd1;
                if (i_q == 12'(N_IN - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                mac_en  = 1'b1;
                state_d = S_BIAS;
            end
            S_BIAS: begin
                bias_en = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                acc_clr = 1'b1;
                if (n_q == 12'(N_OUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + 12'd1;
                    i_d     = '0;
                    wbase_d = wbase_q + WADDR_W'(N_IN + 1);
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            n_q     <= '0;
            wbase_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            wbase_q <= wbase_d;
            busy_q  <= busy_d;
        end
    end

    fc_mac u_mac (
        .clk     (clk),
        .reset   (reset),
        .acc_clr (acc_clr),
        .mac_en  (mac_en),
        .bias_en (bias_en),
        .feat    (cdata_rd),
        .wgt     (wdata),
        .result  (result)
    );

    always_comb begin
        crd      = 1'b0;
        caddr_rd = '0;
        waddr    = '0;
        cwr      = 1'b0;
        caddr_wr = '0;
        cdata_wr = '0;
        csel     = CSEL_NONE;
        case (state_q)
            S_MAC: begin
                crd      = 1'b1;
                caddr_rd = i_q;
                waddr    = wbase_q + WADDR_W'(i_q);
                csel     = CSEL_L1;
            end
            S_DRAIN: begin
                waddr = wbase_q + WADDR_W'(N_IN);
                csel  = CSEL_L1;
            end
            S_BIAS: begin
                csel = CSEL_L1;
            end
            S_WRITE: begin
                cwr      = 1'b1;
                caddr_wr = n_q;
                cdata_wr = result;
                csel     = CSEL_OUT;
            end
            default: begin
            end
        endcase
    end

    assign busy = busy_q;

endmodule
